// File: rtl/mux8to1_rr_collector_if.sv
// Bundle of the eight valid/ready source channels and the merged, channel-tagged output stream.
interface mux8to1_rr_collector_if #(
    parameter int W = 8
);
    logic [7:0]     in_valid;
    logic [8*W-1:0] in_data;
    logic [7:0]     in_last;
    logic [7:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [2:0]     out_sel;
    logic           out_last;
    logic           out_ready;

    // Collector side: consumes the channels, produces the merged stream.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_last
    );

    // Environment side: sources plus downstream sink.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_last
    );
endinterface

// File: rtl/mux8to1_rr_collector.sv
// 8-to-1 packet-granular round-robin collector with a registered output stage.
// Each output beat carries its source channel number so the stream can be split again.
module mux8to1_rr_collector #(
    parameter int W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mux8to1_rr_collector_if.slave      bus
);
    typedef enum logic {ARB, HOLD} state_t;

    state_t       state_reg, state_next;
    logic [2:0]   rr_ptr_reg, rr_ptr_next;
    logic [2:0]   lock_ch_reg, lock_ch_next;

    logic         out_valid_reg;
    logic [W-1:0] out_data_reg;
    logic [2:0]   out_sel_reg;
    logic         out_last_reg;

    logic         load;
    logic         found;
    logic [2:0]   grant;
    logic [2:0]   idx;
    logic [2:0]   sel_ch;
    logic         xfer;
    logic [7:0]   ready_vec;
    logic [W-1:0] ch_data [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_unpack
            assign ch_data[gi] = bus.in_data[gi*W +: W];
        end
    endgenerate

    assign load = !out_valid_reg || bus.out_ready;

    // First valid channel at or after rr_ptr, wrapping 7 -> 0.
    always_comb begin
        found = 1'b0;
        grant = 3'd0;
        idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = rr_ptr_reg + 3'(k);
            if (!found && bus.in_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        lock_ch_next = lock_ch_reg;
        ready_vec    = 8'd0;
        xfer         = 1'b0;
        sel_ch       = lock_ch_reg;
        case (state_reg)
            ARB: begin
                if (load && found) begin
                    xfer             = 1'b1;
                    sel_ch           = grant;
                    ready_vec[grant] = 1'b1;
                    if (bus.in_last[grant]) begin
                        rr_ptr_next = grant + 3'd1;
                    end else begin
                        lock_ch_next = grant;
                        state_next   = HOLD;
                    end
                end
            end
            HOLD: begin
                // Only the locked channel may advance until its packet ends.
                if (load && bus.in_valid[lock_ch_reg]) begin
                    xfer                   = 1'b1;
                    ready_vec[lock_ch_reg] = 1'b1;
                    if (bus.in_last[lock_ch_reg]) begin
                        rr_ptr_next = lock_ch_reg + 3'd1;
                        state_next  = ARB;
                    end
                end
            end
            default: state_next = ARB;
        endcase
    end

    // Sources see no accept while reset is asserted, even before any clock edge.
    assign bus.in_ready = rst_n ? ready_vec : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ARB;
            rr_ptr_reg  <= 3'd0;
            lock_ch_reg <= 3'd0;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            lock_ch_reg <= lock_ch_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= 3'd0;
            out_last_reg  <= 1'b0;
        end else if (xfer) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= ch_data[sel_ch];
            out_sel_reg   <= sel_ch;
            out_last_reg  <= bus.in_last[sel_ch];
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_sel   = out_sel_reg;
    assign bus.out_last  = out_last_reg;
endmodule

// File: tb/tb_mux8to1_rr_collector.sv
// Directed bench for mux8to1_rr_collector: per-cycle vector table plus reset-related sequences.
module tb_mux8to1_rr_collector;
    localparam logic [63:0] D = 64'h1716151413121110;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    mux8to1_rr_collector_if #(.W(8)) bus();

    mux8to1_rr_collector #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  v;
        logic [7:0]  l;
        logic [63:0] d;
        logic        ordy;
        logic [7:0]  exp_rdy;
        logic        exp_ov;
        logic [2:0]  exp_sel;
        logic [7:0]  exp_data;
        logic        exp_last;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] v, input logic [7:0] l, input logic [63:0] d,
                       input logic ordy, input logic [7:0] er, input logic eov,
                       input logic [2:0] es, input logic [7:0] ed, input logic el);
        vec_t t;
        t.v = v; t.l = l; t.d = d; t.ordy = ordy;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_sel = es; t.exp_data = ed; t.exp_last = el;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] v, input logic [7:0] l, input logic [63:0] d,
                         input logic ordy);
        bus.in_valid  = v;
        bus.in_last   = l;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    task automatic check_out(input string tag, input logic ov, input logic [2:0] s,
                             input logic [7:0] dd, input logic la);
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ov));
        check({tag, ".out_sel"},   64'(bus.out_sel),   64'(s));
        check({tag, ".out_data"},  64'(bus.out_data),  64'(dd));
        check({tag, ".out_last"},  64'(bus.out_last),  64'(la));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Round-robin over all channels, single-beat packets, then wrap back to 0.
        for (int k = 0; k < 9; k++)
            add(8'hFF, 8'hFF, D, 1'b1, 8'(8'd1 << (k % 8)), 1'b1, 3'(k % 8), 8'(8'h10 + k % 8), 1'b1);
        // Sparse channels 1 and 7.
        for (int k = 0; k < 2; k++) begin
            add(8'h82, 8'hFF, D, 1'b1, 8'h02, 1'b1, 3'd1, 8'h11, 1'b1);
            add(8'h82, 8'hFF, D, 1'b1, 8'h80, 1'b1, 3'd7, 8'h17, 1'b1);
        end
        // Channel 2 three-beat packet while channel 5 waits.
        add(8'h24, 8'h20, 64'h0000_5500_00AA_0000, 1'b1, 8'h04, 1'b1, 3'd2, 8'hAA, 1'b0);
        add(8'h24, 8'h20, 64'h0000_5500_00BB_0000, 1'b1, 8'h04, 1'b1, 3'd2, 8'hBB, 1'b0);
        add(8'h24, 8'h24, 64'h0000_5500_00CC_0000, 1'b1, 8'h04, 1'b1, 3'd2, 8'hCC, 1'b1);
        add(8'h20, 8'h20, 64'h0000_5500_00CC_0000, 1'b1, 8'h20, 1'b1, 3'd5, 8'h55, 1'b1);
        // Channel 3 locked but idle: channel 0 must not be granted.
        add(8'h08, 8'h00, 64'h0000_0000_3300_0000, 1'b1, 8'h08, 1'b1, 3'd3, 8'h33, 1'b0);
        add(8'h01, 8'hFF, 64'h0000_0000_3300_0010, 1'b1, 8'h00, 1'b0, 3'd3, 8'h33, 1'b0);
        add(8'h09, 8'h08, 64'h0000_0000_3400_0010, 1'b1, 8'h08, 1'b1, 3'd3, 8'h34, 1'b1);
        add(8'h01, 8'h01, 64'h0000_0000_3400_0010, 1'b1, 8'h01, 1'b1, 3'd0, 8'h10, 1'b1);
        // Backpressure for four cycles, then drain and reload in one cycle.
        for (int k = 0; k < 4; k++)
            add(8'hFF, 8'hFF, D, 1'b0, 8'h00, 1'b1, 3'd0, 8'h10, 1'b1);
        add(8'hFF, 8'hFF, D, 1'b1, 8'h02, 1'b1, 3'd1, 8'h11, 1'b1);
        // Nothing valid: output drains, payload registers hold.
        add(8'h00, 8'h00, D, 1'b1, 8'h00, 1'b0, 3'd1, 8'h11, 1'b1);

        // Reset with every channel valid.
        rst_n = 1'b0;
        drive(8'hFF, 8'hFF, D, 1'b1);
        #12;
        check("reset.in_ready", 64'(bus.in_ready), 64'h00);
        check_out("reset", 1'b0, 3'd0, 8'h00, 1'b0);
        drive(8'h00, 8'h00, D, 1'b1);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].ordy);
            #1;
            check($sformatf("vec%0d.in_ready", i), 64'(bus.in_ready), 64'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_sel,
                      vecs[i].exp_data, vecs[i].exp_last);
            $display("vec %0d: in_valid=%02h in_ready=%02h -> out_valid=%0b sel=%0d data=%02h last=%0b",
                     i, vecs[i].v, bus.in_ready, bus.out_valid, bus.out_sel, bus.out_data, bus.out_last);
        end

        // Reset in the middle of a channel 4 packet.
        drive(8'h10, 8'h00, 64'h0000_00A1_0000_0000, 1'b1);
        #1;
        check("midrst.first.in_ready", 64'(bus.in_ready), 64'h10);
        @(posedge clk);
        #1;
        check_out("midrst.first", 1'b1, 3'd4, 8'hA1, 1'b0);
        $display("midrst: beat 1 of channel 4 on output, asserting reset");
        #1 rst_n = 1'b0;
        #1;
        check("midrst.in_ready", 64'(bus.in_ready), 64'h00);
        check_out("midrst.during", 1'b0, 3'd0, 8'h00, 1'b0);
        drive(8'h00, 8'h00, D, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(8'h11, 8'h11, 64'h0000_00A2_0000_0010, 1'b1);
        #1;
        check("midrst.after0.in_ready", 64'(bus.in_ready), 64'h01);
        @(posedge clk);
        #1;
        check_out("midrst.after0", 1'b1, 3'd0, 8'h10, 1'b1);
        $display("midrst: after release, grant channel %0d", bus.out_sel);
        #1;
        check("midrst.after1.in_ready", 64'(bus.in_ready), 64'h10);
        @(posedge clk);
        #1;
        check_out("midrst.after1", 1'b1, 3'd4, 8'hA2, 1'b1);
        $display("midrst: next grant channel %0d", bus.out_sel);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux8to1_rr_collector.md
Name: mux8to1_rr_collector

Overview:
- Sequential counterpart of the 1-to-8 demultiplexer: merges 8 independent valid/ready source channels into one output stream.
- Round-robin arbitration at packet granularity; each output beat is tagged with its 3-bit source channel number, so a downstream demux1to8 can split the stream again.
- Registered output stage: 1-cycle latency, 1 beat/cycle sustained throughput.

Parameters:
- W, 8, data width per channel.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  8  per-channel beat valid.
- in_data  input  8*W  packed channel data; channel i occupies bits [i*W +: W].
- in_last  input  8  per-channel end-of-packet flag, qualified by in_valid.
- in_ready  output  8  per-channel accept; one-hot or zero.
- out_valid  output  1  output beat valid.
- out_data  output  W  output beat data.
- out_sel  output  3  source channel of the current output beat.
- out_last  output  1  end-of-packet flag of the current output beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, out_sel=0, out_last=0, rr_ptr=0, state=ARB, lock_ch=0. in_ready is 0 while rst_n=0.
- Load enable: load = !out_valid || out_ready.
- Output transfer: occurs on a clock edge when out_valid && out_ready.
- Input transfer: occurs on channel i when in_valid[i] && in_ready[i].
- State ARB:
  - When load=1 and |in_valid, grant g = first channel with in_valid set, searching upward from rr_ptr and wrapping 7->0.
  - in_ready[g]=1 combinationally; all other bits of in_ready are 0.
  - If in_last[g]=1: rr_ptr <= (g+1) mod 8 and state stays ARB.
  - Otherwise: lock_ch <= g and state <= HOLD.
- State HOLD:
  - in_ready[lock_ch] = load && in_valid[lock_ch]; all other channels are ignored.
  - When a beat with in_last=1 is accepted: rr_ptr <= (lock_ch+1) mod 8 and state <= ARB.
- Output register update on input transfer: out_data <= granted channel data, out_sel <= channel, out_last <= in_last, out_valid <= 1.
- Output register update with no input transfer: if out_ready=1, out_valid <= 0. Otherwise all output registers hold.
- Output stability: while out_valid=1 && out_ready=0, out_data, out_sel and out_last must not change.
- Latency: input accept at edge N makes the beat visible on the outputs after edge N.
- Throughput: back-to-back beats with continuous out_ready give 1 beat/cycle, including arbitration switches (no bubble).
- Combinational paths: in_ready depends combinationally on in_valid, state and out_ready. Sources must not derive in_valid from in_ready.
- Packet integrity: packets are never interleaved; out_sel stays constant from the first beat of a packet through its last beat.
- Starvation freedom: a channel holding in_valid=1 is granted within 7 packets of other channels.
- Wrap-around: grant from channel 7 sets rr_ptr to 0.
- Single-beat packets (in_last=1 on first beat): grant, then advance rr_ptr in the same cycle.
- Reset mid-packet: state returns to ARB and any buffered beat is discarded (out_valid=0). The partial packet is lost; sources must also be reset.
- HOLD with the locked channel idle (in_valid[lock_ch]=0): output drains and no other channel is granted.

Test Plan:
- Reset: assert rst_n=0 with all in_valid=8'hFF -> in_ready=0, out_valid=0, out_sel=0; release reset -> first grant is channel 0.
- Round-robin, single-beat: in_valid=8'hFF, in_last=8'hFF, channel i data = 8'h10+i, out_ready=1 -> out_sel sequence 0,1,...,7,0; out_data 8'h10..8'h17, one beat per cycle.
- Sparse wrap: in_valid=8'b1000_0010, all in_last=1 -> out_sel alternates 1,7,1,7; after the grant from 7, the next grant is channel 1.
- Packet lock: channel 2 sends a 3-beat packet (AA,BB,CC, last on CC) while channel 5 is valid -> out_sel=2 for AA,BB,CC, then 5; out_last=1 only on CC.
- Backpressure: out_ready=0 for 4 cycles with a beat held -> out_* stable, in_ready=0; out_ready=1 -> beat drains and the next beat loads in the same cycle.
- Reset mid-packet: assert rst_n low after beat 1 of a 3-beat packet on channel 4 -> out_valid=0 and rr_ptr=0; after release, channel 0 is granted first when valid.
